// File: rtl/nexys_reset_request.sv
// Reset-request front end: synchronises and debounces board reset sources and issues a
// minimum-width, cause-tagged reset request to the downstream reset tree.
module nexys_reset_request #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_BITS   = 16,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned COOLDOWN_CYCLES = 256
) (
  input  logic       clock,
  input  logic       areset_n,
  input  logic       btn_n,
  input  logic       locked,
  input  logic       sw_req,
  input  logic       wdt_expire,
  input  logic       cause_clear,
  output logic       reset_req,
  output logic       busy,
  output logic [4:0] cause
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DEB_LAST = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE_WAIT,
    COOLDOWN
  } state_t;

  logic [SYNC_STAGES-1:0]   btn_sync_q;
  logic [SYNC_STAGES-1:0]   lock_sync_q;
  logic [DEBOUNCE_BITS-1:0] deb_cnt_q;
  logic                     btn_stable_q;
  logic                     btn_prev_q;
  logic                     lock_seen_q;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] cool_cnt_q, cool_cnt_d;
  logic          pending_q, pending_d;
  logic [4:0]    cause_q, cause_d;
  logic          reset_req_q;
  logic          busy_q;

  logic       btn_sync;
  logic       lock_sync;
  logic       btn_press;
  logic       lock_loss;
  logic       other_trig;
  logic       pend_now;
  logic [4:0] trig;

  assign btn_sync  = btn_sync_q[SYNC_STAGES-1];
  assign lock_sync = lock_sync_q[SYNC_STAGES-1];
  assign btn_press = btn_prev_q & ~btn_stable_q;
  // Lock loss only counts once lock has been seen since reset, so the power-on wait for
  // the first lock does not restart the hold or tag the request as a lock loss.
  assign lock_loss  = lock_seen_q & ~lock_sync;
  assign other_trig = btn_press | sw_req | wdt_expire;
  assign trig       = {lock_loss, wdt_expire, sw_req, btn_press, 1'b0};

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      btn_sync_q   <= '1;
      lock_sync_q  <= '0;
      deb_cnt_q    <= '0;
      btn_stable_q <= 1'b1;
      btn_prev_q   <= 1'b1;
      lock_seen_q  <= 1'b0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
      btn_prev_q  <= btn_stable_q;
      lock_seen_q <= lock_seen_q | lock_sync;
      if (btn_sync != btn_stable_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          btn_stable_q <= btn_sync;
          deb_cnt_q    <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEBOUNCE_BITS'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cool_cnt_d = cool_cnt_q;
    pending_d  = pending_q;
    pend_now   = pending_q | other_trig;
    cause_d    = (cause_clear ? 5'b00000 : cause_q) | trig;
    case (state_q)
      IDLE: begin
        if (other_trig || lock_loss) begin
          state_d    = ASSERT;
          hold_cnt_d = '0;
          pending_d  = 1'b0;
        end
      end
      ASSERT: begin
        if (lock_loss) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RELEASE_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (btn_stable_q && lock_sync) begin
          state_d    = COOLDOWN;
          cool_cnt_d = '0;
        end
      end
      COOLDOWN: begin
        if (lock_loss) begin
          state_d    = ASSERT;
          hold_cnt_d = '0;
          pending_d  = 1'b0;
        end else if (cool_cnt_q == COOL_LAST) begin
          state_d    = pend_now ? ASSERT : IDLE;
          hold_cnt_d = '0;
          pending_d  = 1'b0;
        end else begin
          cool_cnt_d = cool_cnt_q + CW'(1);
          pending_d  = pend_now;
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ASSERT;
      hold_cnt_q  <= '0;
      cool_cnt_q  <= '0;
      pending_q   <= 1'b0;
      cause_q     <= 5'b00001;
      reset_req_q <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      pending_q   <= pending_d;
      cause_q     <= cause_d;
      reset_req_q <= (state_d == ASSERT) || (state_d == RELEASE_WAIT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign reset_req = reset_req_q;
  assign busy      = busy_q;
  assign cause     = cause_q;

endmodule
